// File: rtl/moa_seq_ctrl.sv
// Sequential multi-operand approximate adder: exact high part, OR-merged low K bits.
// Define MOA_SEQ_EC_EN to add a COMP cycle that compensates lost carries.
module moa_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int K     = 4,
    parameter int MAXN  = 8,
    localparam int CW   = $clog2(MAXN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH+CW-1:0]   out_sum,
    output logic [CW-1:0]         out_cnt,
    output logic [CW-1:0]         out_err,
    output logic                  busy
);

    localparam int HW = WIDTH - K + CW;
    localparam int SW = WIDTH + CW;

`ifdef MOA_SEQ_EC_EN
    typedef enum logic [1:0] {IDLE, ACC, COMP, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
`endif

    state_t          state_q, state_d;
    logic [HW-1:0]   hi_q, hi_d;
    logic [K-1:0]    lo_q, lo_d;
    logic [CW-1:0]   n_q, n_d;
    logic [CW-1:0]   err_q, err_d;
    logic [SW-1:0]   out_sum_q, out_sum_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   out_err_q, out_err_d;

    logic [HW-1:0]   op_hi;
    logic [K-1:0]    op_lo;
    logic            accept;
    logic            group_end;
    logic            lost_carry;

    assign op_hi      = {{CW{1'b0}}, in_data[WIDTH-1:K]};
    assign op_lo      = in_data[K-1:0];
    assign in_ready   = (state_q == IDLE) || (state_q == ACC);
    assign accept     = in_valid && in_ready;
    assign lost_carry = |(lo_q & op_lo);

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_err   = out_err_q;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        n_d       = n_q;
        err_d     = err_q;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        out_err_d = out_err_q;
        group_end = 1'b0;

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        hi_d  = op_hi;
                        lo_d  = op_lo;
                        n_d   = CW'(1);
                        err_d = '0;
                    end else begin
                        hi_d  = hi_q + op_hi;
                        lo_d  = lo_q | op_lo;
                        n_d   = n_q + CW'(1);
                        err_d = err_q + {{(CW-1){1'b0}}, lost_carry};
                    end
                    // Hitting MAXN closes the group even without in_last.
                    group_end = in_last || (n_d == CW'(MAXN));
                    if (group_end) begin
`ifdef MOA_SEQ_EC_EN
                        state_d = COMP;
`else
                        state_d   = HOLD;
                        out_sum_d = {hi_d, lo_d};
                        out_cnt_d = n_d;
                        out_err_d = err_d;
`endif
                    end else begin
                        state_d = ACC;
                    end
                end
            end
`ifdef MOA_SEQ_EC_EN
            COMP: begin
                // Each lost carry is worth on average half of the low-part weight.
                out_sum_d = {hi_q, lo_q} + (SW'(err_q) << (K - 1));
                out_cnt_d = n_q;
                out_err_d = err_q;
                state_d   = HOLD;
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            n_q       <= '0;
            err_q     <= '0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_err_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            n_q       <= n_d;
            err_q     <= err_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
            out_err_q <= out_err_d;
        end
    end

endmodule

// File: tb/tb_moa_seq_ctrl.sv
// Scoreboard bench for moa_seq_ctrl (WIDTH=16, K=4, MAXN=8); expectations follow MOA_SEQ_EC_EN.
module tb_moa_seq_ctrl;

   localparam int WIDTH = 16;
   localparam int K     = 4;
   localparam int MAXN  = 8;
   localparam int CW    = 4;

`ifdef MOA_SEQ_EC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [WIDTH+CW-1:0] sum;
      logic [CW-1:0]       cnt;
      logic [CW-1:0]       err;
      int                  lat;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    in_data;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH+CW-1:0] out_sum;
   logic [CW-1:0]       out_cnt;
   logic [CW-1:0]       out_err;
   logic                busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   lastAcceptCyc = 0;
   exp_t expQ[$];

   moa_seq_ctrl #(.WIDTH(WIDTH), .K(K), .MAXN(MAXN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cnt   (out_cnt),
      .out_err   (out_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; holds the operand until it is accepted, then idles the bus with junk.
   task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last);
      int waitCycles = 0;
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      while (!in_ready && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!in_ready) checkOutput("accept timeout", 32'd0, 32'd1);
      lastAcceptCyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      in_last  = 1'b1;
   endtask

   task automatic pushExp(input logic [WIDTH+CW-1:0] sum, input logic [CW-1:0] cnt, input logic [CW-1:0] err);
      exp_t e;
      e.sum = sum;
      e.cnt = cnt;
      e.err = err;
      e.lat = LAT;
      expQ.push_back(e);
   endtask

   task automatic waitIdle();
      int waitCycles = 0;
      while ((busy || out_valid) && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      if (busy || out_valid) checkOutput("idle timeout", 32'd0, 32'd1);
   endtask

   // Monitor: pops an expectation when a result appears and re-checks it while it is held.
   initial begin
      exp_t cur;
      logic prevValid = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (!prevValid) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected result", 32'd1, 32'd0);
                  cur.sum = out_sum;
                  cur.cnt = out_cnt;
                  cur.err = out_err;
                  cur.lat = 0;
               end else begin
                  cur = expQ.pop_front();
                  checkOutput("out_sum", 32'(out_sum), 32'(cur.sum));
                  checkOutput("out_cnt", 32'(out_cnt), 32'(cur.cnt));
                  checkOutput("out_err", 32'(out_err), 32'(cur.err));
                  checkOutput("latency", 32'(cyc - lastAcceptCyc), 32'(cur.lat));
               end
            end else begin
               checkOutput("hold out_sum", 32'(out_sum), 32'(cur.sum));
               checkOutput("hold out_cnt", 32'(out_cnt), 32'(cur.cnt));
               checkOutput("hold out_err", 32'(out_err), 32'(cur.err));
            end
            checkOutput("in_ready while valid", 32'(in_ready), 32'd0);
            checkOutput("busy while valid", 32'(busy), 32'd1);
         end
         prevValid = out_valid;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset out_sum", 32'(out_sum), 32'd0);
      checkOutput("reset out_cnt", 32'(out_cnt), 32'd0);
      checkOutput("reset out_err", 32'(out_err), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);

      $display("[TB] single operand");
      pushExp(20'h01234, 4'd1, 4'd0);
      applyStimulus(16'h1234, 1'b1);
      waitIdle();

      $display("[TB] lost carry");
`ifdef MOA_SEQ_EC_EN
      pushExp(20'h0000B, 4'd2, 4'd1);
`else
      pushExp(20'h00003, 4'd2, 4'd1);
`endif
      applyStimulus(16'h0003, 1'b0);
      applyStimulus(16'h0001, 1'b1);
      waitIdle();

      $display("[TB] MAXN forced end");
`ifdef MOA_SEQ_EC_EN
      pushExp(20'h7FFC7, 4'd8, 4'd7);
`else
      pushExp(20'h7FF8F, 4'd8, 4'd7);
`endif
      out_ready = 1'b0;
      for (int i = 0; i < MAXN; i++) applyStimulus(16'hFFFF, 1'b0);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      in_last  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("ninth stalls", 32'(in_ready), 32'd0);
         checkOutput("ninth busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitIdle();

      $display("[TB] backpressure");
      pushExp(20'h00030, 4'd2, 4'd0);
      out_ready = 1'b0;
      applyStimulus(16'h0010, 1'b0);
      applyStimulus(16'h0020, 1'b1);
      begin
         int waitCycles = 0;
         while (!out_valid && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
         end
         checkOutput("result appears", 32'(out_valid), 32'd1);
      end
      repeat (3) @(negedge clk);
      checkOutput("held 4th cycle", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("consumed out_valid", 32'(out_valid), 32'd0);
      checkOutput("consumed busy", 32'(busy), 32'd0);
      checkOutput("consumed in_ready", 32'(in_ready), 32'd1);

      $display("[TB] reset mid-group");
      applyStimulus(16'h0111, 1'b0);
      applyStimulus(16'h0222, 1'b0);
      applyStimulus(16'h0333, 1'b0);
      checkOutput("in ACC busy", 32'(busy), 32'd1);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h0444;
      in_last  = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid reset out_sum", 32'(out_sum), 32'd0);
      checkOutput("mid reset out_cnt", 32'(out_cnt), 32'd0);
      checkOutput("mid reset out_err", 32'(out_err), 32'd0);
      checkOutput("mid reset busy", 32'(busy), 32'd0);
      checkOutput("mid reset in_ready", 32'(in_ready), 32'd1);
      pushExp(20'h00005, 4'd1, 4'd0);
      applyStimulus(16'h0005, 1'b1);
      waitIdle();

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
